// File: rtl/tx_buf_pkg.sv
// Purpose : shared sizes and types for the USB transmit payload buffer.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
package tx_buf_pkg;

  localparam int BUF_DEPTH = 64;
  localparam int BUF_OCC_W = 7;
  localparam int BUF_PTR_W = 6;

  typedef logic [7:0]           byte_t;
  typedef logic [BUF_PTR_W-1:0] buf_ptr_t;

endpackage : tx_buf_pkg

// File: rtl/tx_buf_ptr.sv
// Purpose : wrapping buffer pointer with increment enable and synchronous reset/clear.
// Latency : pointer advances on the edge where i_inc is sampled high.
// Backpr. : none; the caller only asserts i_inc for accepted transfers.
//
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - synchronous active-high reset (highest priority)
//   i_clr  - synchronous clear, same effect as reset
//   i_inc  - advance pointer by one, wrapping naturally at 2^W
//   o_ptr  - current pointer value
module tx_buf_ptr
  import tx_buf_pkg::*;
#(
  parameter int W = BUF_PTR_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);

  localparam logic [W-1:0] PTR_ONE = W'(1);

  logic [W-1:0] r_ptr;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + PTR_ONE;
    end
  end

  assign o_ptr = r_ptr;

endmodule : tx_buf_ptr

// File: rtl/tx_data_buffer.sv
// Purpose : first-word-fall-through byte FIFO holding outbound USB payload.
// Latency : write-to-read 1 cycle; occupancy/flags/error pulses registered (1 cycle).
// Backpr. : push refused when full (overflow_err), pop refused when empty (underflow_err).
//
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   clear               - synchronous flush (like reset, but no error pulses)
//   store_tx_data/tx_data        - host push strobe and byte
//   get_tx_packet_data          - transmitter pop strobe
//   tx_packet_data      - head byte, 8'h00 when empty
//   buffer_occupancy    - bytes held, 0..DEPTH
//   buf_full/buf_empty  - occupancy == DEPTH / == 0
//   overflow_err/underflow_err  - one-cycle pulses for refused push/pop
//   almost_empty        - only with TX_BUF_WATERMARK_EN: occupancy <= LOW_WM
module tx_data_buffer
  import tx_buf_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH,
  parameter int OCC_W = BUF_OCC_W
`ifdef TX_BUF_WATERMARK_EN
  ,
  parameter int LOW_WM = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             store_tx_data,
  input  logic [7:0]       tx_data,
  input  logic             get_tx_packet_data,
  output logic [7:0]       tx_packet_data,
  output logic [OCC_W-1:0] buffer_occupancy,
  output logic             buf_full,
  output logic             buf_empty,
  output logic             overflow_err,
  output logic             underflow_err
`ifdef TX_BUF_WATERMARK_EN
  ,
  output logic             almost_empty
`endif
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

  byte_t            r_mem [DEPTH];
  logic [OCC_W-1:0] r_occ;
  logic             r_full;
  logic             r_empty;
  logic             r_ovf;
  logic             r_unf;

  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;
  logic             w_push;
  logic             w_pop;
  logic [OCC_W-1:0] w_occ_nxt;

  // Pop needs a byte present. Push needs a free slot, except that a full
  // buffer popping this cycle frees the slot being written (wr_ptr == rd_ptr).
  assign w_pop  = get_tx_packet_data && !r_empty;
  assign w_push = store_tx_data && (!r_full || w_pop);

  always_comb begin
    w_occ_nxt = r_occ;
    if (w_push && !w_pop) begin
      w_occ_nxt = r_occ + OCC_ONE;
    end else if (w_pop && !w_push) begin
      w_occ_nxt = r_occ - OCC_ONE;
    end
  end

  tx_buf_ptr #(.W(PTR_W)) u_wr_ptr (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (clear),
    .i_inc (w_push),
    .o_ptr (w_wr_ptr)
  );

  tx_buf_ptr #(.W(PTR_W)) u_rd_ptr (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (clear),
    .i_inc (w_pop),
    .o_ptr (w_rd_ptr)
  );

  // Storage is deliberately not reset; empty-state output masking hides stale bytes.
  always_ff @(posedge clk) begin
    if (w_push && !rst && !clear) begin
      r_mem[w_wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_occ   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_occ   <= w_occ_nxt;
      r_full  <= (w_occ_nxt == OCC_FULL);
      r_empty <= (w_occ_nxt == '0);
      r_ovf   <= store_tx_data && !w_push;
      r_unf   <= get_tx_packet_data && !w_pop;
    end
  end

`ifdef TX_BUF_WATERMARK_EN
  localparam logic [OCC_W-1:0] OCC_LOW_WM = OCC_W'(LOW_WM);

  logic r_almost_empty;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_almost_empty <= 1'b1;
    end else begin
      r_almost_empty <= (w_occ_nxt <= OCC_LOW_WM);
    end
  end

  assign almost_empty = r_almost_empty;
`endif

  assign tx_packet_data   = r_empty ? 8'h00 : r_mem[w_rd_ptr];
  assign buffer_occupancy = r_occ;
  assign buf_full         = r_full;
  assign buf_empty        = r_empty;
  assign overflow_err     = r_ovf;
  assign underflow_err    = r_unf;

endmodule : tx_data_buffer

// File: tb/tb_tx_data_buffer.sv
// Purpose : directed self-checking bench for tx_data_buffer.
// Latency : inputs driven 1 time unit after a rising edge, outputs sampled 1 unit after the next.
// Backpr. : exercises full/empty refusal and simultaneous push/pop corners.
module tb_tx_data_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       store_tx_data;
  logic [7:0] tx_data;
  logic       get_tx_packet_data;
  logic [7:0] tx_packet_data;
  logic [6:0] buffer_occupancy;
  logic       buf_full;
  logic       buf_empty;
  logic       overflow_err;
  logic       underflow_err;
`ifdef TX_BUF_WATERMARK_EN
  logic       almost_empty;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  tx_data_buffer dut (
    .clk                (clk),
    .rst                (rst),
    .clear              (clear),
    .store_tx_data      (store_tx_data),
    .tx_data            (tx_data),
    .get_tx_packet_data (get_tx_packet_data),
    .tx_packet_data     (tx_packet_data),
    .buffer_occupancy   (buffer_occupancy),
    .buf_full           (buf_full),
    .buf_empty          (buf_empty),
    .overflow_err       (overflow_err),
    .underflow_err      (underflow_err)
`ifdef TX_BUF_WATERMARK_EN
    ,
    .almost_empty       (almost_empty)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; clear = 1'b0; store_tx_data = 1'b0; get_tx_packet_data = 1'b0; tx_data = 8'h00;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset then idle
    check("rst_occ",   buffer_occupancy, 0);
    check("rst_empty", buf_empty, 1);
    check("rst_full",  buf_full, 0);
    check("rst_data",  tx_packet_data, 8'h00);
    check("rst_ovf",   overflow_err, 0);
    check("rst_unf",   underflow_err, 0);
`ifdef TX_BUF_WATERMARK_EN
    check("rst_ae", almost_empty, 1);
`endif

    // Push three bytes, then pop them
    store_tx_data = 1'b1;
    tx_data = 8'hA5; tick(); check("p1_occ", buffer_occupancy, 1); check("p1_data", tx_packet_data, 8'hA5);
    tx_data = 8'h3C; tick(); check("p2_occ", buffer_occupancy, 2);
    tx_data = 8'hFF; tick(); check("p3_occ", buffer_occupancy, 3); check("p3_data", tx_packet_data, 8'hA5);
    store_tx_data = 1'b0;
    get_tx_packet_data = 1'b1;
    tick(); check("q1_data", tx_packet_data, 8'h3C); check("q1_occ", buffer_occupancy, 2);
    tick(); check("q2_data", tx_packet_data, 8'hFF); check("q2_occ", buffer_occupancy, 1);
    tick(); check("q3_data", tx_packet_data, 8'h00); check("q3_occ", buffer_occupancy, 0);
    check("q3_empty", buf_empty, 1);
    get_tx_packet_data = 1'b0;

    // Pop while empty: underflow pulse, state unchanged
    get_tx_packet_data = 1'b1; tick(); get_tx_packet_data = 1'b0;
    check("pe_unf", underflow_err, 1); check("pe_occ", buffer_occupancy, 0);
    tick(); check("pe_unf_clr", underflow_err, 0);

    // Fill 64 bytes, then overflow
    store_tx_data = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tx_data = 8'(i); tick();
    end
    store_tx_data = 1'b0;
    check("fill_full", buf_full, 1);
    check("fill_occ",  buffer_occupancy, 64);
    check("fill_ovf0", overflow_err, 0);
`ifdef TX_BUF_WATERMARK_EN
    check("fill_ae", almost_empty, 0);
`endif
    store_tx_data = 1'b1; tx_data = 8'h77; tick(); store_tx_data = 1'b0;
    check("ovf_pulse", overflow_err, 1);
    check("ovf_occ",   buffer_occupancy, 64);
    tick(); check("ovf_clr", overflow_err, 0);
    get_tx_packet_data = 1'b1;
    for (int i = 0; i < 64; i++) begin
      check("drain_data", tx_packet_data, 32'(i));
      tick();
    end
    get_tx_packet_data = 1'b0;
    check("drain_empty", buf_empty, 1);
    check("drain_data_z", tx_packet_data, 8'h00);

    // Full with simultaneous push and pop
    store_tx_data = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tx_data = 8'(i); tick();
    end
    check("fpp_full0", buf_full, 1);
    tx_data = 8'h80; get_tx_packet_data = 1'b1; tick();
    store_tx_data = 1'b0;
    check("fpp_occ",  buffer_occupancy, 64);
    check("fpp_ovf",  overflow_err, 0);
    check("fpp_unf",  underflow_err, 0);
    check("fpp_head", tx_packet_data, 8'h01);
    for (int k = 1; k < 64; k++) begin
      check("fpp_seq", tx_packet_data, 32'(k));
      tick();
    end
    check("fpp_last", tx_packet_data, 8'h80);
    check("fpp_occ1", buffer_occupancy, 1);
    tick();
    get_tx_packet_data = 1'b0;
    check("fpp_empty", buf_empty, 1);

    // Empty with simultaneous push and pop
    store_tx_data = 1'b1; get_tx_packet_data = 1'b1; tx_data = 8'h11; tick();
    store_tx_data = 1'b0; get_tx_packet_data = 1'b0;
    check("epp_unf",  underflow_err, 1);
    check("epp_occ",  buffer_occupancy, 1);
    check("epp_data", tx_packet_data, 8'h11);
    check("epp_ovf",  overflow_err, 0);
    get_tx_packet_data = 1'b1; tick(); get_tx_packet_data = 1'b0;
    check("epp_unf2", underflow_err, 0);
    check("epp_empty", buf_empty, 1);

    // Clear together with push and pop
    store_tx_data = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tx_data = 8'(8'h20 + i); tick();
    end
    check("ld_occ", buffer_occupancy, 10);
    clear = 1'b1; tx_data = 8'hEE; get_tx_packet_data = 1'b1; tick();
    clear = 1'b0; get_tx_packet_data = 1'b0;
    tx_data = 8'h5A;
    check("clr_occ",   buffer_occupancy, 0);
    check("clr_empty", buf_empty, 1);
    check("clr_data",  tx_packet_data, 8'h00);
    check("clr_ovf",   overflow_err, 0);
    check("clr_unf",   underflow_err, 0);
    tick(); store_tx_data = 1'b0;
    check("clr_new_data", tx_packet_data, 8'h5A);
    check("clr_new_occ",  buffer_occupancy, 1);
    get_tx_packet_data = 1'b1; tick(); get_tx_packet_data = 1'b0;
    check("clr_pop_empty", buf_empty, 1);

    // Reset mid-stream
    store_tx_data = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tx_data = 8'(8'h40 + i); tick();
    end
    check("ld2_occ", buffer_occupancy, 10);
    rst = 1'b1; tx_data = 8'hEE; get_tx_packet_data = 1'b1; tick();
    rst = 1'b0; get_tx_packet_data = 1'b0;
    tx_data = 8'hC3;
    check("rs_occ",   buffer_occupancy, 0);
    check("rs_empty", buf_empty, 1);
    check("rs_data",  tx_packet_data, 8'h00);
    check("rs_ovf",   overflow_err, 0);
    check("rs_unf",   underflow_err, 0);
    tick(); store_tx_data = 1'b0;
    check("rs_new_data", tx_packet_data, 8'hC3);
    get_tx_packet_data = 1'b1; tick(); get_tx_packet_data = 1'b0;
    check("rs_pop_empty", buf_empty, 1);
    check("rs_pop_data",  tx_packet_data, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_tx_data_buffer
